// File: rtl/agu_alu_stage.sv
// ----------------------------------------------------------------------------
// agu_alu_stage
//
// Address-generation plus integer-ALU pipeline stage for the x86-subset core.
// A single load-enabled input register bank captures operands and controls.
// The linear address, the ALU result and its CF/AF/OF flags are then computed
// combinationally from those registered values. Results appear one cycle after
// a load and feed the memory-read stage registers.
//
// Ports
//   clk      in   1   rising-edge clock
//   r        in   1   synchronous active-low reset
//   e        in   1   load enable for the input register bank
//   v_in     in   1   valid
//   re_in    in   1   memory read enable
//   we_in    in   1   memory write enable
//   rmsel    in   1   r/m base select: 1 = dval, 0 = sval
//   dval     in  32   base operand / ALU operand A
//   sval     in  32   source operand / ALU operand B / next EIP for relative jumps
//   disp     in  32   displacement / absolute jump offset
//   sreg     in  16   segment selector value
//   modrm    in   8   ModR/M byte (only mod = [7:6] is used)
//   jmp      in   3   jump control ([2] direct, [1] relative, [0] unused)
//   alusel   in   2   ALU op: 00 ADD, 01 OR, 10 AND, 11 SUB
//   v/re/we  out  1   registered copies of v_in/re_in/we_in
//   addr     out 32   linear address = (sreg << 4) + offset, wrapping
//   alu_out  out 32   ALU result
//   cf/af/of out  1   carry/borrow, auxiliary carry (bit 3 -> 4), signed overflow
// ----------------------------------------------------------------------------
module agu_alu_stage (
    input  logic        clk,
    input  logic        r,
    input  logic        e,
    input  logic        v_in,
    input  logic        re_in,
    input  logic        we_in,
    input  logic        rmsel,
    input  logic [31:0] dval,
    input  logic [31:0] sval,
    input  logic [31:0] disp,
    input  logic [15:0] sreg,
    input  logic [7:0]  modrm,
    input  logic [2:0]  jmp,
    input  logic [1:0]  alusel,
    output logic        v,
    output logic        re,
    output logic        we,
    output logic [31:0] addr,
    output logic [31:0] alu_out,
    output logic        cf,
    output logic        af,
    output logic        of
);

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_OR  = 2'b01,
        ALU_AND = 2'b10,
        ALU_SUB = 2'b11
    } alu_op_t;

    // Input register bank. Only the fields that influence the outputs are kept:
    // mod = modrm[7:6] and jmp[2:1].
    logic        r_v;
    logic        r_re;
    logic        r_we;
    logic        r_rmsel;
    logic [31:0] r_dval;
    logic [31:0] r_sval;
    logic [31:0] r_disp;
    logic [15:0] r_sreg;
    logic [1:0]  r_mod;
    logic        r_jmp_direct;
    logic        r_jmp_rel;
    alu_op_t     r_alusel;

    // NOTE: every flop in the bank is cleared on reset so the stage presents
    // v=re=we=0 and a defined address/result immediately; reset wins over e.
    always_ff @(posedge clk) begin
        if (!r) begin
            // NOTE: non-blocking assignments for all sequential state so every
            // register samples the pre-edge values, independent of statement order.
            r_v          <= 1'b0;
            r_re         <= 1'b0;
            r_we         <= 1'b0;
            r_rmsel      <= 1'b0;
            r_dval       <= '0;
            r_sval       <= '0;
            r_disp       <= '0;
            r_sreg       <= '0;
            r_mod        <= '0;
            r_jmp_direct <= 1'b0;
            r_jmp_rel    <= 1'b0;
            r_alusel     <= ALU_ADD;
        end else if (e) begin
            r_v          <= v_in;
            r_re         <= re_in;
            r_we         <= we_in;
            r_rmsel      <= rmsel;
            r_dval       <= dval;
            r_sval       <= sval;
            r_disp       <= disp;
            r_sreg       <= sreg;
            r_mod        <= modrm[7:6];
            r_jmp_direct <= jmp[2];
            r_jmp_rel    <= jmp[1];
            r_alusel     <= alu_op_t'(alusel);
        end
    end

    // reg/rm fields of ModR/M and jmp[0] carry no meaning for this stage.
    logic w_unused_bits;
    assign w_unused_bits = ^{modrm[5:0], jmp[0]};

    assign v  = r_v;
    assign re = r_re;
    assign we = r_we;

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    logic [31:0] w_base;
    logic [31:0] w_disp8;
    logic [31:0] w_ea;
    logic [31:0] w_offset;
    logic [31:0] w_seg_base;

    assign w_base     = r_rmsel ? r_dval : r_sval;
    assign w_disp8    = {{24{r_disp[7]}}, r_disp[7:0]};
    assign w_seg_base = {12'b0, r_sreg, 4'b0};

    always_comb begin
        // NOTE: defaults first so no path through the block leaves a variable
        // unassigned, which would otherwise infer a latch.
        w_ea     = '0;
        w_offset = '0;

        case (r_mod)
            2'b00:   w_ea = w_base;
            2'b01:   w_ea = w_base + w_disp8;
            2'b10:   w_ea = w_base + r_disp;
            default: w_ea = '0;   // register operand: no memory address
        endcase

        // Direct jump beats relative jump beats the ModR/M effective address.
        if (r_jmp_direct) begin
            w_offset = r_disp;
        end else if (r_jmp_rel) begin
            w_offset = r_sval + r_disp;
        end else begin
            w_offset = w_ea;
        end
    end

    // Real-mode style segmentation; overflow past 4 GiB simply wraps.
    assign addr = w_seg_base + w_offset;

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    logic [32:0] w_add;
    logic [32:0] w_sub;

    assign w_add = {1'b0, r_dval} + {1'b0, r_sval};
    assign w_sub = {1'b0, r_dval} - {1'b0, r_sval};

    always_comb begin
        alu_out = '0;
        cf      = 1'b0;
        af      = 1'b0;
        of      = 1'b0;

        case (r_alusel)
            ALU_ADD: begin
                alu_out = w_add[31:0];
                cf      = w_add[32];
                // Carry into bit 4 is recovered from the bit-4 sum: R4 = A4 ^ B4 ^ c4.
                af      = r_dval[4] ^ r_sval[4] ^ w_add[4];
                of      = (r_dval[31] == r_sval[31]) && (w_add[31] != r_dval[31]);
            end
            ALU_OR: begin
                alu_out = r_dval | r_sval;
            end
            ALU_AND: begin
                alu_out = r_dval & r_sval;
            end
            ALU_SUB: begin
                alu_out = w_sub[31:0];
                // The 33rd bit of a zero-extended subtraction is the unsigned borrow.
                cf      = w_sub[32];
                // Same identity as ADD: borrow into bit 4 is A4 ^ B4 ^ R4.
                af      = r_dval[4] ^ r_sval[4] ^ w_sub[4];
                of      = (r_dval[31] != r_sval[31]) && (w_sub[31] != r_dval[31]);
            end
            default: begin
                alu_out = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_agu_alu_stage.sv
// ----------------------------------------------------------------------------
// tb_agu_alu_stage
//
// Self-checking bench for agu_alu_stage. Each clocked step pushes the result
// expected after the edge onto a scoreboard queue; one time unit after the
// edge the entry is popped and compared with the DUT outputs. Directed steps
// push hand-derived constants; the random phase pushes values from a small
// reference model written with wide integer arithmetic.
// ----------------------------------------------------------------------------
module tb_agu_alu_stage;

    typedef struct packed {
        logic        v_in;
        logic        re_in;
        logic        we_in;
        logic        rmsel;
        logic [31:0] dval;
        logic [31:0] sval;
        logic [31:0] disp;
        logic [15:0] sreg;
        logic [7:0]  modrm;
        logic [2:0]  jmp;
        logic [1:0]  alusel;
    } stim_t;

    typedef struct packed {
        logic        v;
        logic        re;
        logic        we;
        logic        cf;
        logic        af;
        logic        of;
        logic [31:0] addr;
        logic [31:0] alu;
    } exp_t;

    logic        clk;
    logic        r;
    logic        e;
    logic        v_in;
    logic        re_in;
    logic        we_in;
    logic        rmsel;
    logic [31:0] dval;
    logic [31:0] sval;
    logic [31:0] disp;
    logic [15:0] sreg;
    logic [7:0]  modrm;
    logic [2:0]  jmp;
    logic [1:0]  alusel;
    logic        v;
    logic        re;
    logic        we;
    logic [31:0] addr;
    logic [31:0] alu_out;
    logic        cf;
    logic        af;
    logic        of;

    int   n_checks;
    int   n_fail;
    int   step_no;
    exp_t sb_q[$];

    agu_alu_stage dut (
        .clk     (clk),
        .r       (r),
        .e       (e),
        .v_in    (v_in),
        .re_in   (re_in),
        .we_in   (we_in),
        .rmsel   (rmsel),
        .dval    (dval),
        .sval    (sval),
        .disp    (disp),
        .sreg    (sreg),
        .modrm   (modrm),
        .jmp     (jmp),
        .alusel  (alusel),
        .v       (v),
        .re      (re),
        .we      (we),
        .addr    (addr),
        .alu_out (alu_out),
        .cf      (cf),
        .af      (af),
        .of      (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step=%0d got=0x%08h exp=0x%08h", tag, step_no, got, exp);
        end
    endtask

    function automatic exp_t mkexp(input logic ev, input logic ere, input logic ewe,
                                   input logic ecf, input logic eaf, input logic eof,
                                   input logic [31:0] eaddr, input logic [31:0] ealu);
        exp_t x;
        x.v    = ev;
        x.re   = ere;
        x.we   = ewe;
        x.cf   = ecf;
        x.af   = eaf;
        x.of   = eof;
        x.addr = eaddr;
        x.alu  = ealu;
        return x;
    endfunction

    // Reference model: integer arithmetic on 64-bit quantities, range tests
    // for carry/overflow, explicit mod-2^32 truncation.
    function automatic exp_t model(input stim_t s);
        exp_t        x;
        longint      a_u;
        longint      b_u;
        longint      a_s;
        longint      b_s;
        longint      res;
        longint      base;
        longint      ea;
        longint      off;
        logic [63:0] wide;

        a_u = longint'(s.dval);
        b_u = longint'(s.sval);
        a_s = longint'($signed(s.dval));
        b_s = longint'($signed(s.sval));

        x      = '0;
        x.v    = s.v_in;
        x.re   = s.re_in;
        x.we   = s.we_in;

        base = s.rmsel ? a_u : b_u;
        case (s.modrm[7:6])
            2'b00:   ea = base;
            2'b01:   ea = base + longint'($signed(s.disp[7:0]));
            2'b10:   ea = base + longint'(s.disp);
            default: ea = 0;
        endcase
        if (s.jmp[2])      off = longint'(s.disp);
        else if (s.jmp[1]) off = b_u + longint'(s.disp);
        else               off = ea;
        wide   = 64'(longint'(s.sreg) * 16 + off);
        x.addr = wide[31:0];

        case (s.alusel)
            2'b00: begin
                res   = a_u + b_u;
                wide  = 64'(res);
                x.alu = wide[31:0];
                x.cf  = (res > 64'sh0_FFFF_FFFF);
                x.af  = ((a_u & 15) + (b_u & 15)) > 15;
                res   = a_s + b_s;
                x.of  = (res > 64'sh7FFF_FFFF) || (res < -64'sh8000_0000);
            end
            2'b01: x.alu = s.dval | s.sval;
            2'b10: x.alu = s.dval & s.sval;
            default: begin
                wide  = 64'(a_u - b_u);
                x.alu = wide[31:0];
                x.cf  = (a_u < b_u);
                x.af  = (a_u & 15) < (b_u & 15);
                res   = a_s - b_s;
                x.of  = (res > 64'sh7FFF_FFFF) || (res < -64'sh8000_0000);
            end
        endcase
        return x;
    endfunction

    task automatic apply(input stim_t s, input logic en, input logic rst_val);
        r      = rst_val;
        e      = en;
        v_in   = s.v_in;
        re_in  = s.re_in;
        we_in  = s.we_in;
        rmsel  = s.rmsel;
        dval   = s.dval;
        sval   = s.sval;
        disp   = s.disp;
        sreg   = s.sreg;
        modrm  = s.modrm;
        jmp    = s.jmp;
        alusel = s.alusel;
    endtask

    // One clock; compare the oldest scoreboard entry just after the edge.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        step_no++;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            x = sb_q.pop_front();
            check("addr",    addr,    x.addr);
            check("alu_out", alu_out, x.alu);
            check("flags",   {29'b0, cf, af, of}, {29'b0, x.cf, x.af, x.of});
            check("ctl",     {29'b0, v, re, we},  {29'b0, x.v, x.re, x.we});
        end
    endtask

    task automatic dstep(input stim_t s, input logic en, input logic rst_val, input exp_t x);
        apply(s, en, rst_val);
        sb_q.push_back(x);
        tick();
    endtask

    initial begin
        stim_t s;
        exp_t  zero;
        exp_t  held;

        n_checks = 0;
        n_fail   = 0;
        step_no  = 0;
        zero     = '0;
        s        = '0;
        apply(s, 1'b0, 1'b0);
        #2;

        // Reset held for two edges with e=1 and live inputs.
        s = '0; s.dval = 32'd5; s.v_in = 1'b1; s.re_in = 1'b1; s.we_in = 1'b1;
        dstep(s, 1'b1, 1'b0, zero);
        dstep(s, 1'b1, 1'b0, zero);

        // Basic load, then hold with e=0 while inputs change.
        s = '0; s.dval = 32'd2; s.sval = 32'h0000_ABCD; s.modrm = 8'hC0;
        s.v_in = 1'b1; s.re_in = 1'b1;
        dstep(s, 1'b1, 1'b1, mkexp(1, 1, 0, 0, 0, 0, 32'h0, 32'h0000_ABCF));
        s.dval = 32'hFFFF_FFFF; s.sval = 32'd1; s.alusel = 2'b11; s.v_in = 1'b0;
        s.sreg = 16'h1234; s.we_in = 1'b1;
        dstep(s, 1'b0, 1'b1, mkexp(1, 1, 0, 0, 0, 0, 32'h0, 32'h0000_ABCF));

        // ALU corner cases (mod=11 keeps the address at 0).
        s = '0; s.modrm = 8'hC0; s.v_in = 1'b1;
        s.dval = 32'hFFFF_FFFF; s.sval = 32'd1; s.alusel = 2'b00;
        dstep(s, 1'b1, 1'b1, mkexp(1, 0, 0, 1, 1, 0, 32'h0, 32'h0000_0000));
        s.dval = 32'h7FFF_FFFF;
        dstep(s, 1'b1, 1'b1, mkexp(1, 0, 0, 0, 1, 1, 32'h0, 32'h8000_0000));
        s.dval = 32'h0; s.sval = 32'd1; s.alusel = 2'b11;
        dstep(s, 1'b1, 1'b1, mkexp(1, 0, 0, 1, 1, 0, 32'h0, 32'hFFFF_FFFF));
        s.dval = 32'h0000_00F0; s.sval = 32'h0000_000F; s.alusel = 2'b01;
        dstep(s, 1'b1, 1'b1, mkexp(1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_00FF));
        s.alusel = 2'b10;
        dstep(s, 1'b1, 1'b1, mkexp(1, 0, 0, 0, 0, 0, 32'h0, 32'h0000_0000));

        // Direct and relative jumps with a segment base.
        s = '0; s.sreg = 16'hFFF0; s.disp = 32'd3; s.jmp = 3'b100; s.we_in = 1'b1;
        dstep(s, 1'b1, 1'b1, mkexp(0, 0, 1, 0, 0, 0, 32'h000F_FF03, 32'h0));
        s.jmp = 3'b010; s.sval = 32'h0000_ABCD;
        dstep(s, 1'b1, 1'b1, mkexp(0, 0, 1, 0, 0, 0, 32'h0010_AAD0, 32'h0000_ABCD));

        // Effective address by mod, both base selects; jmp[0] has no effect.
        s = '0; s.rmsel = 1'b1; s.dval = 32'h100; s.modrm = 8'h00;
        dstep(s, 1'b1, 1'b1, mkexp(0, 0, 0, 0, 0, 0, 32'h100, 32'h100));
        s.modrm = 8'h40; s.disp = 32'h0000_00FF;
        dstep(s, 1'b1, 1'b1, mkexp(0, 0, 0, 0, 0, 0, 32'h0FF, 32'h100));
        s.modrm = 8'h80; s.disp = 32'h0000_0020;
        dstep(s, 1'b1, 1'b1, mkexp(0, 0, 0, 0, 0, 0, 32'h120, 32'h100));
        s.modrm = 8'hC0;
        dstep(s, 1'b1, 1'b1, mkexp(0, 0, 0, 0, 0, 0, 32'h000, 32'h100));
        s.rmsel = 1'b0; s.sval = 32'h40; s.modrm = 8'h00;
        dstep(s, 1'b1, 1'b1, mkexp(0, 0, 0, 0, 0, 0, 32'h040, 32'h140));
        s.jmp = 3'b001;
        dstep(s, 1'b1, 1'b1, mkexp(0, 0, 0, 0, 0, 0, 32'h040, 32'h140));

        // Address wrap, then reset mid-stream with e=1.
        s = '0; s.sreg = 16'hFFFF; s.jmp = 3'b100; s.disp = 32'hFFFF_FFFF; s.re_in = 1'b1;
        dstep(s, 1'b1, 1'b1, mkexp(0, 1, 0, 0, 0, 0, 32'h000F_FFEF, 32'h0));
        s.v_in = 1'b1; s.dval = 32'h1234_5678; s.sval = 32'h1;
        dstep(s, 1'b1, 1'b0, zero);

        // Random phase: model-driven, with random enable and occasional reset.
        held = zero;
        for (int i = 0; i < 200; i++) begin
            logic en;
            logic rst_val;
            s.v_in   = 1'($urandom());
            s.re_in  = 1'($urandom());
            s.we_in  = 1'($urandom());
            s.rmsel  = 1'($urandom());
            s.dval   = $urandom();
            s.sval   = (i % 5 == 0) ? s.dval : $urandom();
            s.disp   = $urandom();
            s.sreg   = 16'($urandom());
            s.modrm  = 8'($urandom());
            s.jmp    = 3'($urandom());
            s.alusel = 2'($urandom());
            en       = ($urandom_range(0, 3) != 0);
            rst_val  = ($urandom_range(0, 15) != 0);
            if (!rst_val)  held = zero;
            else if (en)   held = model(s);
            apply(s, en, rst_val);
            sb_q.push_back(held);
            tick();
        end

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
